// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the multi-word instruction register.
//   state_e       : assembly state (IDLE awaiting opcode, EXT collecting
//                   extension words, FULL holding a complete instruction)
//   DEF_*         : default word width, opcode width and extension limit
//   lenExceeds()  : true when an opcode's length field asks for more
//                   extension words than the register can hold
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam int DEF_W      = 8;
  localparam int DEF_OPW    = 4;
  localparam int DEF_MAXEXT = 2;

  // The length field is narrow enough to encode values above the limit
  // (e.g. 3 when only 2 extension words exist), so it needs range checking.
  function automatic logic lenExceeds(input int unsigned n,
                                      input int unsigned maxExt);
    return n > maxExt;
  endfunction

endpackage

// File: rtl/ir_word_reg.sv
// ir_word_reg: W-bit storage word with synchronous clear and load enable.
//   clk : rising-edge clock
//   clr : synchronous active-high clear (wins over ld)
//   ld  : load d on the next edge
//   d   : data in
//   q   : stored word
module ir_word_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;

  // Clear has priority so a new opcode capture can wipe stale extension
  // words on the same edge that would otherwise be a no-op for them.
  always_ff @(posedge clk) begin
    if (clr) begin
      word_q <= '0;
    end else if (ld) begin
      word_q <= d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/ir_multiword.sv
// ir_multiword: instruction register assembling one opcode word plus up to
// MAXEXT extension words from the shared bus, holding the result until the
// controller acknowledges it.
//   clk, clr : clock, synchronous active-high reset
//   i, li    : bus word and load strobe (one word per asserted cycle)
//   ei, esel : tri-state drive enable and field select (0 = short immediate,
//              k = extension word k)
//   ack      : controller has consumed the held instruction
//   bus      : tri-state field output, high-Z when ei=0
//   ctrl     : opcode (top OPW bits of the opcode word)
//   operand  : extension words, word k in bits [k*W-1:(k-1)*W]
//   ext_cnt  : number of extension words in the held instruction
//   valid    : complete instruction held
//   busy     : waiting for extension words
//   illegal  : length field exceeded MAXEXT (clamped to MAXEXT)
module ir_multiword
  import ir_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int OPW    = DEF_OPW,
  parameter int MAXEXT = DEF_MAXEXT,
  localparam int LENW  = $clog2(MAXEXT + 1)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [W-1:0]          i,
  input  logic                  li,
  input  logic                  ei,
  input  logic [LENW-1:0]       esel,
  input  logic                  ack,
  output logic [W-1:0]          bus,
  output logic [OPW-1:0]        ctrl,
  output logic [MAXEXT*W-1:0]   operand,
  output logic [LENW-1:0]       ext_cnt,
  output logic                  valid,
  output logic                  busy,
  output logic                  illegal
);

  localparam logic [LENW-1:0] MAXEXT_L = LENW'(MAXEXT);

  state_e          state_q, state_d;
  logic [LENW-1:0] idx_q, idx_d;
  logic [LENW-1:0] ext_cnt_q, ext_cnt_d;
  logic            illegal_q, illegal_d;

  logic            capture;
  logic            ext_clr;
  logic [LENW-1:0] len_raw;
  logic [LENW-1:0] len_clamp;
  logic            len_over;
  logic [MAXEXT-1:0] ext_ld;
  logic [W-1:0]    op_word;
  logic [W-1:0]    ext_word [MAXEXT];
  logic [W-1:0]    bus_val;

  // The length field is the low LENW bits of the opcode, read straight off
  // the incoming word so the decision is made on the capture edge itself.
  assign len_raw   = i[W-OPW +: LENW];
  assign len_over  = lenExceeds(32'(len_raw), MAXEXT);
  assign len_clamp = len_over ? MAXEXT_L : len_raw;

  // State, word index, length and illegal flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ext_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ext_cnt_q <= ext_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. A capture happens in IDLE on li, or in FULL when ack
  // and li coincide so back-to-back instructions need no idle cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ext_cnt_d = ext_cnt_q;
    illegal_d = illegal_q;
    capture   = 1'b0;
    ext_ld    = '0;
    unique case (state_q)
      IDLE: begin
        if (li) capture = 1'b1;
      end
      EXT: begin
        if (li) begin
          for (int k = 0; k < MAXEXT; k++) begin
            ext_ld[k] = (idx_q == LENW'(k + 1));
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == ext_cnt_q) state_d = FULL;
        end
      end
      FULL: begin
        if (ack) begin
          if (li) capture = 1'b1;
          else    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      ext_cnt_d = len_clamp;
      illegal_d = len_over;
      idx_d     = LENW'(1);
      state_d   = (len_clamp == '0) ? FULL : EXT;
    end
  end

  // Extension words from a previous instruction are wiped on every capture.
  assign ext_clr = clr | capture;

  ir_word_reg #(.W(W)) u_op_reg (
    .clk (clk),
    .clr (clr),
    .ld  (capture),
    .d   (i),
    .q   (op_word)
  );

  for (genvar g = 0; g < MAXEXT; g++) begin : g_ext
    ir_word_reg #(.W(W)) u_ext_reg (
      .clk (clk),
      .clr (ext_clr),
      .ld  (ext_ld[g]),
      .d   (i),
      .q   (ext_word[g])
    );
    assign operand[g*W +: W] = ext_word[g];
  end

  // Bus field mux; independent of state, selects beyond the held length
  // read as zero.
  always_comb begin
    bus_val = '0;
    if (esel == '0) begin
      bus_val = {{OPW{1'b0}}, op_word[W-OPW-1:0]};
    end else if (esel <= ext_cnt_q) begin
      for (int k = 0; k < MAXEXT; k++) begin
        if (esel == LENW'(k + 1)) bus_val = ext_word[k];
      end
    end
  end

  assign bus     = ei ? bus_val : {W{1'bz}};
  assign ctrl    = op_word[W-1 -: OPW];
  assign ext_cnt = ext_cnt_q;
  assign illegal = illegal_q;
  assign valid   = (state_q == FULL);
  assign busy    = (state_q == EXT);

endmodule
